// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use and HI/LO interlocks,
// wrong-path flush on taken branches, mult/div sequencing and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_md_use,
  input  logic             ex_memrd,
  input  logic [4:0]       ex_rt,
  input  logic             ex_md_start,
  input  logic             ex_br_taken,
  output logic             pc_wr,
  output logic             ifid_wr,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MDC_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
  localparam logic [MDC_W-1:0] MDC_LOAD = MDC_W'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [MDC_W-1:0] r_md_cnt;
  logic [MDC_W-1:0] w_md_cnt_nxt;
  logic             r_md_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_lu_haz;
  logic             w_md_haz;
  logic             w_md_busy;
  logic             w_start_err;

  always_comb begin
    w_lu_haz  = ex_memrd && (ex_rt != 5'd0) &&
                ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
    w_md_busy = (r_state != MD_IDLE);
    w_md_haz  = id_md_use && w_md_busy;
  end

  // Mult/div sequencer: a start while BUSY or DONE is dropped and flagged.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_start_err  = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (ex_md_start) begin
          w_state_nxt  = MD_BUSY;
          w_md_cnt_nxt = MDC_LOAD;
        end
      end
      MD_BUSY: begin
        w_start_err = ex_md_start;
        if (r_md_cnt == '0) begin
          w_state_nxt = MD_DONE;
        end else begin
          w_md_cnt_nxt = r_md_cnt - MDC_W'(1);
        end
      end
      MD_DONE: begin
        w_start_err = ex_md_start;
        w_state_nxt = MD_IDLE;
      end
      default: begin
        w_state_nxt = MD_IDLE;
      end
    endcase
  end

  // Pipeline control: reset holds everything, a taken branch beats any hazard.
  always_comb begin
    pc_wr      = 1'b1;
    ifid_wr    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst) begin
      pc_wr      = 1'b0;
      ifid_wr    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_lu_haz || w_md_haz) begin
      pc_wr      = 1'b0;
      ifid_wr    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    md_busy   = w_md_busy && !rst;
    md_done   = (r_state == MD_DONE) && !rst;
    md_err    = r_md_err;
    stall_cnt = r_stall_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= MD_IDLE;
      r_md_cnt    <= '0;
      r_md_err    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      if (w_start_err) begin
        r_md_err <= 1'b1;
      end
      if (!pc_wr && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: table and sequence vectors queue their expected outputs
// when driven; a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;

  localparam int MDC = 4;
  localparam int CW  = 4;

  localparam logic [3:0] RUN = 4'b1100;  // {pc_wr, ifid_wr, ifid_flush, idex_flush}
  localparam logic [3:0] STL = 4'b0001;
  localparam logic [3:0] FLU = 4'b1111;
  localparam logic [3:0] RSC = 4'b0011;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_use_rs, id_use_rt, id_md_use, ex_memrd, ex_md_start, ex_br_taken;
  logic          pc_wr, ifid_wr, ifid_flush, idex_flush, md_busy, md_done, md_err;
  logic [CW-1:0] stall_cnt;

  pipe_hazard_ctrl #(.MD_CYCLES(MDC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_md_use(id_md_use), .ex_memrd(ex_memrd), .ex_rt(ex_rt),
    .ex_md_start(ex_md_start), .ex_br_taken(ex_br_taken),
    .pc_wr(pc_wr), .ifid_wr(ifid_wr), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .md_busy(md_busy), .md_done(md_done), .md_err(md_err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       md_use;
    logic       memrd;
    logic [4:0] ert;
    logic       start;
    logic       br;
    logic [3:0] ctl;
    logic [2:0] md;   // {md_busy, md_done, md_err}
  } vec_t;

  typedef struct {
    int            tag;
    logic [3:0]    ctl;
    logic [2:0]    md;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  exp_t          me;
  int            n_vec  = 0;
  int            n_miss = 0;
  logic [CW-1:0] m_cnt  = '0;
  bit            m_pend = 1'b0;
  vec_t          tbl[12];

  function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic mdu,
                              input logic mrd, input logic [4:0] ert, input logic st,
                              input logic b, input logic [3:0] ctl, input logic [2:0] md);
    vec_t v;
    v.rst = r; v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt; v.md_use = mdu;
    v.memrd = mrd; v.ert = ert; v.start = st; v.br = b; v.ctl = ctl; v.md = md;
    return v;
  endfunction

  function automatic vec_t mdv(input logic st, input logic mdu, input logic b,
                               input logic [3:0] ctl, input logic [2:0] md);
    return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, mdu, 1'b0, 5'd0, st, b, ctl, md);
  endfunction

  function automatic vec_t rstv();
    return mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, RSC, 3'b000);
  endfunction

  // Drive one vector just after the rising edge and queue what it must produce.
  task automatic apply(input vec_t v, input int tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (m_pend && (m_cnt != CMAX)) m_cnt = m_cnt + 1'b1;
    m_pend = 1'b0;
    if (v.rst) m_cnt = '0;
    rst = v.rst; id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
    id_md_use = v.md_use; ex_memrd = v.memrd; ex_rt = v.ert;
    ex_md_start = v.start; ex_br_taken = v.br;
    e.tag = tag; e.ctl = v.ctl; e.md = v.md; e.cnt = m_cnt;
    sb.push_back(e);
    m_pend = !v.rst && !v.ctl[3];
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      n_vec++;
      if (({pc_wr, ifid_wr, ifid_flush, idex_flush} !== me.ctl) ||
          ({md_busy, md_done, md_err} !== me.md) || (stall_cnt !== me.cnt)) begin
        n_miss++;
        $display("FAIL vec %0d: got ctl=%b md=%b cnt=%0d, expected ctl=%b md=%b cnt=%0d",
                 me.tag, {pc_wr, ifid_wr, ifid_flush, idex_flush},
                 {md_busy, md_done, md_err}, stall_cnt, me.ctl, me.md, me.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors pending", sb.size());
    $fatal(1);
  end

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_md_use = 1'b0; ex_memrd = 1'b0; ex_rt = '0; ex_md_start = 1'b0; ex_br_taken = 1'b0;

    //            rst   rs     rt     urs   urt   mdu   mrd   ert    st    br    ctl  md
    tbl[0]  = rstv();
    tbl[1]  = mk(1'b0, 5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, STL, 3'b000);
    tbl[2]  = mk(1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, RUN, 3'b000);
    tbl[3]  = mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, RUN, 3'b000);
    tbl[4]  = mk(1'b0, 5'd1,  5'd7,  1'b0, 1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, STL, 3'b000);
    tbl[5]  = mk(1'b0, 5'd3,  5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, RUN, 3'b000);
    tbl[6]  = mk(1'b0, 5'd7,  5'd2,  1'b0, 1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, RUN, 3'b000);
    tbl[7]  = mk(1'b0, 5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0, RUN, 3'b000);
    tbl[8]  = mk(1'b0, 5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b1, FLU, 3'b000);
    tbl[9]  = mk(1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, FLU, 3'b000);
    tbl[10] = mk(1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, RUN, 3'b000);
    tbl[11] = mk(1'b0, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, STL, 3'b000);
    for (int i = 0; i < 12; i++) apply(tbl[i], 100 + i);

    // HI/LO consumer held in ID across a full mult/div: 5 stall cycles.
    apply(rstv(), 200);
    apply(mdv(1'b1, 1'b1, 1'b0, RUN, 3'b000), 201);
    for (int k = 0; k < 4; k++) apply(mdv(1'b0, 1'b1, 1'b0, STL, 3'b100), 202 + k);
    apply(mdv(1'b0, 1'b1, 1'b0, STL, 3'b110), 206);
    apply(mdv(1'b0, 1'b1, 1'b0, RUN, 3'b000), 207);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b000), 208);

    // Reset in the middle of BUSY, then a clean full run.
    apply(rstv(), 300);
    apply(mdv(1'b1, 1'b0, 1'b0, RUN, 3'b000), 301);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b100), 302);
    apply(rstv(), 303);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b000), 304);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b000), 305);
    apply(mdv(1'b1, 1'b0, 1'b0, RUN, 3'b000), 306);
    for (int k = 0; k < 4; k++) apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b100), 307 + k);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b110), 311);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b000), 312);

    // Second start while BUSY and a taken branch mid-operation.
    apply(rstv(), 400);
    apply(mdv(1'b1, 1'b0, 1'b0, RUN, 3'b000), 401);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b100), 402);
    apply(mdv(1'b1, 1'b0, 1'b0, RUN, 3'b100), 403);
    apply(mdv(1'b0, 1'b1, 1'b1, FLU, 3'b101), 404);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b101), 405);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b111), 406);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b001), 407);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b001), 408);

    // Start arriving in DONE is an error and does not begin a new operation.
    apply(rstv(), 500);
    apply(mdv(1'b1, 1'b0, 1'b0, RUN, 3'b000), 501);
    for (int k = 0; k < 4; k++) apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b100), 502 + k);
    apply(mdv(1'b1, 1'b0, 1'b0, RUN, 3'b110), 506);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b001), 507);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b001), 508);

    // 20 load-use stall cycles against a 4-bit counter.
    apply(rstv(), 600);
    for (int k = 0; k < 20; k++)
      apply(mk(1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, STL, 3'b000), 601 + k);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b000), 621);
    apply(mdv(1'b0, 1'b0, 1'b0, RUN, 3'b000), 622);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected results left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
